// File: rtl/z80_io_decoder_if.sv
// ============================================================================
// Module      : z80_io_decoder_if
// Description : Bus bundle between the Z80 side and the I/O decoder.
//               Carries the Z80 address/data/control inputs, the device
//               read-back bus, and all decoder outputs (device index,
//               config-window select, per-device strobes, read data).
//               master = Z80/system side, slave = decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface z80_io_decoder_if;
    logic [7:0]  i_addr;       // Z80 A[7:0]
    logic [7:0]  i_data;       // Z80 D[7:0] write data
    logic        i_iorq_n;     // IORQ, active low
    logic        i_rd_n;       // RD, active low
    logic        i_wr_n;       // WR, active low
    logic        i_m1_n;       // M1, active low
    logic [31:0] i_dev_rdata;  // device n read data at [8n+7:8n]
    logic [1:0]  o_device;     // combinational device index
    logic        o_cfg_cs_n;   // config window write select, active low
    logic [1:0]  o_cfg_addr;   // config register index
    logic [1:0]  o_local_addr; // registered A[1:0]
    logic [7:0]  o_wdata;      // registered write data
    logic [3:0]  o_wr_stb;     // one-cycle write strobe per device
    logic [3:0]  o_rd_stb;     // one-cycle read strobe per device
    logic [7:0]  o_data;       // registered read data to Z80
    logic        o_data_oe;    // drive enable for o_data

    modport master (
        output i_addr, i_data, i_iorq_n, i_rd_n, i_wr_n, i_m1_n, i_dev_rdata,
        input  o_device, o_cfg_cs_n, o_cfg_addr, o_local_addr, o_wdata,
               o_wr_stb, o_rd_stb, o_data, o_data_oe
    );

    modport slave (
        input  i_addr, i_data, i_iorq_n, i_rd_n, i_wr_n, i_m1_n, i_dev_rdata,
        output o_device, o_cfg_cs_n, o_cfg_addr, o_local_addr, o_wdata,
               o_wr_stb, o_rd_stb, o_data, o_data_oe
    );
endinterface

`default_nettype wire

// File: rtl/z80_io_decoder.sv
// ============================================================================
// Module      : z80_io_decoder
// Description : Z80 I/O-space front end. Decodes IORQ cycles into four
//               4-port device windows plus a config window, issues one
//               read or write strobe per IORQ assertion, and registers
//               device read data back onto the Z80 data bus.
// Ports       : i_clk   - Z80-domain clock
//               i_reset - asynchronous reset, active high
//               bus     - z80_io_decoder_if.slave (Z80 bus in, strobes out)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module z80_io_decoder #(
    parameter logic [7:0] DEV0_BASE = 8'h00,
    parameter logic [7:0] DEV1_BASE = 8'h10,
    parameter logic [7:0] DEV2_BASE = 8'h20,
    parameter logic [7:0] DEV3_BASE = 8'h30,
    parameter logic [7:0] CFG_BASE  = 8'hF0
) (
    input  wire logic          i_clk,
    input  wire logic          i_reset,
    z80_io_decoder_if.slave    bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;
    localparam logic [1:0] S_IACK   = 2'd3;

    logic [1:0] r_state_q,  w_state_d;
    logic [1:0] r_dev_q,    w_dev_d;
    logic [1:0] r_laddr_q,  w_laddr_d;
    logic [7:0] r_wdata_q,  w_wdata_d;
    logic [3:0] r_wr_stb_q, w_wr_stb_d;
    logic [3:0] r_rd_stb_q, w_rd_stb_d;
    logic [7:0] r_data_q,   w_data_d;
    logic       r_oe_q,     w_oe_d;
    logic       r_rd_act_q, w_rd_act_d;
    logic       r_iorq_q;

    logic       w_hit_cfg;
    logic       w_mapped;
    logic [1:0] w_dev_idx;
    logic       w_iorq_fall;

    // Window decode: CFG outranks the device windows, then DEV0..DEV3.
    assign w_hit_cfg = (bus.i_addr[7:2] == CFG_BASE[7:2]);

    always_comb begin
        w_mapped  = 1'b0;
        w_dev_idx = 2'd0;
        if (w_hit_cfg) begin
            w_mapped  = 1'b0;
        end else if (bus.i_addr[7:2] == DEV0_BASE[7:2]) begin
            w_mapped  = 1'b1;
            w_dev_idx = 2'd0;
        end else if (bus.i_addr[7:2] == DEV1_BASE[7:2]) begin
            w_mapped  = 1'b1;
            w_dev_idx = 2'd1;
        end else if (bus.i_addr[7:2] == DEV2_BASE[7:2]) begin
            w_mapped  = 1'b1;
            w_dev_idx = 2'd2;
        end else if (bus.i_addr[7:2] == DEV3_BASE[7:2]) begin
            w_mapped  = 1'b1;
            w_dev_idx = 2'd3;
        end
    end

    assign bus.o_device   = w_dev_idx;
    assign bus.o_cfg_cs_n = ~(~bus.i_iorq_n & bus.i_m1_n & ~bus.i_wr_n & w_hit_cfg);
    assign bus.o_cfg_addr = bus.i_addr[1:0];

    // r_iorq_q resets low so an IORQ already asserted when reset releases
    // is not seen as a fresh cycle; only a real high-to-low edge starts one.
    assign w_iorq_fall = r_iorq_q & ~bus.i_iorq_n;

    always_comb begin
        w_state_d  = r_state_q;
        w_dev_d    = r_dev_q;
        w_laddr_d  = r_laddr_q;
        w_wdata_d  = r_wdata_q;
        w_wr_stb_d = 4'b0000;
        w_rd_stb_d = 4'b0000;
        // Read stays live only while both RD and IORQ remain asserted.
        w_rd_act_d = r_rd_act_q & ~bus.i_rd_n & ~bus.i_iorq_n;
        w_oe_d     = r_rd_act_q & ~bus.i_rd_n & ~bus.i_iorq_n;
        w_data_d   = r_data_q;
        // Capture device data the clock after the read strobe.
        if (r_rd_stb_q != 4'b0000) begin
            w_data_d = bus.i_dev_rdata[{r_dev_q, 3'b000} +: 8];
        end

        case (r_state_q)
            S_IDLE: begin
                if (w_iorq_fall && !bus.i_m1_n) begin
                    w_state_d = S_IACK;
                end else if (w_iorq_fall && w_mapped) begin
                    w_state_d = S_ACTIVE;
                    w_dev_d   = w_dev_idx;
                    w_laddr_d = bus.i_addr[1:0];
                    w_wdata_d = bus.i_data;
                end else if (w_iorq_fall) begin
                    w_state_d = S_DONE;
                end
            end
            S_ACTIVE: begin
                if (bus.i_iorq_n) begin
                    w_state_d = S_IDLE;
                end else if (!bus.i_wr_n) begin
                    // Write wins when RD and WR are both low.
                    w_wr_stb_d = 4'b0001 << r_dev_q;
                    w_wdata_d  = bus.i_data;
                    w_state_d  = S_DONE;
                end else if (!bus.i_rd_n) begin
                    w_rd_stb_d = 4'b0001 << r_dev_q;
                    w_rd_act_d = 1'b1;
                    w_state_d  = S_DONE;
                end
            end
            S_DONE, S_IACK: begin
                if (bus.i_iorq_n) begin
                    w_state_d = S_IDLE;
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state_q  <= S_IDLE;
            r_dev_q    <= 2'd0;
            r_laddr_q  <= 2'd0;
            r_wdata_q  <= 8'h00;
            r_wr_stb_q <= 4'b0000;
            r_rd_stb_q <= 4'b0000;
            r_data_q   <= 8'h00;
            r_oe_q     <= 1'b0;
            r_rd_act_q <= 1'b0;
            r_iorq_q   <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_dev_q    <= w_dev_d;
            r_laddr_q  <= w_laddr_d;
            r_wdata_q  <= w_wdata_d;
            r_wr_stb_q <= w_wr_stb_d;
            r_rd_stb_q <= w_rd_stb_d;
            r_data_q   <= w_data_d;
            r_oe_q     <= w_oe_d;
            r_rd_act_q <= w_rd_act_d;
            r_iorq_q   <= bus.i_iorq_n;
        end
    end

    assign bus.o_local_addr = r_laddr_q;
    assign bus.o_wdata      = r_wdata_q;
    assign bus.o_wr_stb     = r_wr_stb_q;
    assign bus.o_rd_stb     = r_rd_stb_q;
    assign bus.o_data       = r_data_q;
    assign bus.o_data_oe    = r_oe_q;

endmodule

`default_nettype wire

// File: tb/tb_z80_io_decoder.sv
// ============================================================================
// Module      : tb_z80_io_decoder
// Description : Directed bench for z80_io_decoder. Expected values are
//               queued as each step is driven and popped when the DUT
//               output is sampled 1 ns after the clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_z80_io_decoder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    z80_io_decoder_if bus();

    z80_io_decoder dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard_empty observed %h expected queued entry", obs);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.i_iorq_n = 1'b1;
        bus.i_rd_n   = 1'b1;
        bus.i_wr_n   = 1'b1;
        bus.i_m1_n   = 1'b1;
    endtask

    task automatic chk_no_stb(input string tag);
        push({tag, "_wr_stb"}, 4'b0000);
        push({tag, "_rd_stb"}, 4'b0000);
        push({tag, "_oe"},     1'b0);
        pop_chk(bus.o_wr_stb);
        pop_chk(bus.o_rd_stb);
        pop_chk(bus.o_data_oe);
    endtask

    // Full OUT cycle to a mapped device: one strobe on the second edge only.
    task automatic out_cycle(input logic [7:0] addr, input logic [7:0] data,
                             input logic [3:0] stb);
        bus.i_addr = addr; bus.i_data = data;
        bus.i_iorq_n = 1'b0; bus.i_wr_n = 1'b0;
        tick();
        push("out_edge1_wr_stb", 4'b0000); pop_chk(bus.o_wr_stb);
        tick();
        push("out_wr_stb", stb);   pop_chk(bus.o_wr_stb);
        push("out_wdata", data);   pop_chk(bus.o_wdata);
        push("out_laddr", addr[1:0]); pop_chk(bus.o_local_addr);
        tick();
        push("out_edge3_wr_stb", 4'b0000); pop_chk(bus.o_wr_stb);
        bus_idle();
        tick();
    endtask

    initial begin
        bus.i_addr      = 8'h00;
        bus.i_data      = 8'h00;
        bus.i_dev_rdata = 32'h5C77_2211;
        bus_idle();

        // Reset state
        tick(); tick();
        push("rst_wr_stb", 4'b0000); pop_chk(bus.o_wr_stb);
        push("rst_rd_stb", 4'b0000); pop_chk(bus.o_rd_stb);
        push("rst_data",   8'h00);   pop_chk(bus.o_data);
        push("rst_wdata",  8'h00);   pop_chk(bus.o_wdata);
        push("rst_laddr",  2'd0);    pop_chk(bus.o_local_addr);
        push("rst_oe",     1'b0);    pop_chk(bus.o_data_oe);
        rst = 1'b0;
        tick();

        // OUT (0x12),0xA5: device index valid as IORQ falls
        bus.i_addr = 8'h12; bus.i_data = 8'hA5;
        bus.i_iorq_n = 1'b0; bus.i_wr_n = 1'b0;
        #1;
        push("out12_device", 2'd1); pop_chk(bus.o_device);
        push("out12_cfg_cs", 1'b1); pop_chk(bus.o_cfg_cs_n);
        tick();
        push("out12_edge1_stb", 4'b0000); pop_chk(bus.o_wr_stb);
        tick();
        push("out12_wr_stb", 4'b0010); pop_chk(bus.o_wr_stb);
        push("out12_wdata",  8'hA5);   pop_chk(bus.o_wdata);
        push("out12_laddr",  2'd2);    pop_chk(bus.o_local_addr);
        tick();
        push("out12_edge3_stb", 4'b0000); pop_chk(bus.o_wr_stb);
        bus_idle();
        tick();

        // IN from 0x31, IORQ held 5 clocks
        bus.i_addr = 8'h31; bus.i_iorq_n = 1'b0; bus.i_rd_n = 1'b0;
        #1;
        push("in31_device", 2'd3); pop_chk(bus.o_device);
        tick();
        chk_no_stb("in31_e1");
        tick();
        push("in31_rd_stb", 4'b1000); pop_chk(bus.o_rd_stb);
        push("in31_e2_oe",  1'b0);    pop_chk(bus.o_data_oe);
        for (int i = 0; i < 3; i++) begin
            tick();
            push("in31_hold_rd_stb", 4'b0000); pop_chk(bus.o_rd_stb);
            push("in31_hold_oe",     1'b1);    pop_chk(bus.o_data_oe);
            push("in31_hold_data",   8'h5C);   pop_chk(bus.o_data);
        end
        bus_idle();
        tick();
        push("in31_end_oe", 1'b0); pop_chk(bus.o_data_oe);
        tick();

        // OUT (0xF2),0x03 to config window
        bus.i_addr = 8'hF2; bus.i_data = 8'h03;
        bus.i_iorq_n = 1'b0; bus.i_wr_n = 1'b0;
        #1;
        push("cfg_cs_n",   1'b0); pop_chk(bus.o_cfg_cs_n);
        push("cfg_addr",   2'd2); pop_chk(bus.o_cfg_addr);
        push("cfg_device", 2'd0); pop_chk(bus.o_device);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_no_stb("cfg");
        end
        bus_idle();
        #1;
        push("cfg_cs_n_off", 1'b1); pop_chk(bus.o_cfg_cs_n);
        tick();

        // Interrupt acknowledge at 0x10 (RD also low to expose false strobes)
        bus.i_addr = 8'h10; bus.i_iorq_n = 1'b0; bus.i_m1_n = 1'b0; bus.i_rd_n = 1'b0;
        #1;
        push("iack_cfg_cs", 1'b1); pop_chk(bus.o_cfg_cs_n);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_no_stb("iack");
        end
        bus_idle();
        tick();

        // Unmapped 0x80 read
        bus.i_addr = 8'h80; bus.i_iorq_n = 1'b0; bus.i_rd_n = 1'b0;
        #1;
        push("unmap_device", 2'd0); pop_chk(bus.o_device);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_no_stb("unmap");
        end
        bus_idle();
        tick();

        // Back-to-back OUTs to 0x00 and 0x20
        out_cycle(8'h00, 8'h11, 4'b0001);
        out_cycle(8'h20, 8'h22, 4'b0100);

        // Illegal RD+WR together on 0x13: write wins
        bus.i_addr = 8'h13; bus.i_data = 8'h3C;
        bus.i_iorq_n = 1'b0; bus.i_wr_n = 1'b0; bus.i_rd_n = 1'b0;
        tick(); tick();
        push("rdwr_wr_stb", 4'b0010); pop_chk(bus.o_wr_stb);
        push("rdwr_rd_stb", 4'b0000); pop_chk(bus.o_rd_stb);
        tick();
        push("rdwr_oe", 1'b0); pop_chk(bus.o_data_oe);
        bus_idle();
        tick();

        // Aborted cycle: IORQ rises before WR is seen
        bus.i_addr = 8'h11; bus.i_iorq_n = 1'b0;
        tick();
        bus.i_iorq_n = 1'b1; bus.i_wr_n = 1'b0;
        tick();
        push("abort_wr_stb", 4'b0000); pop_chk(bus.o_wr_stb);
        bus_idle();
        tick();

        // Reset mid-read of 0x21
        bus.i_addr = 8'h21; bus.i_iorq_n = 1'b0; bus.i_rd_n = 1'b0;
        tick(); tick();
        push("rr_rd_stb", 4'b0100); pop_chk(bus.o_rd_stb);
        tick();
        push("rr_oe",   1'b1);  pop_chk(bus.o_data_oe);
        push("rr_data", 8'h77); pop_chk(bus.o_data);
        #2;
        rst = 1'b1;
        #1;
        push("rr_async_oe",   1'b0);  pop_chk(bus.o_data_oe);
        push("rr_async_data", 8'h00); pop_chk(bus.o_data);
        tick();
        #2;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_no_stb("rr_post");
        end
        bus_idle();
        tick();

        // Recovery: a fresh read works after IORQ has risen
        bus.i_addr = 8'h02; bus.i_iorq_n = 1'b0; bus.i_rd_n = 1'b0;
        tick(); tick();
        push("rec_rd_stb", 4'b0001); pop_chk(bus.o_rd_stb);
        tick();
        push("rec_data", 8'h11); pop_chk(bus.o_data);
        bus_idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
